// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with selectable registered or first-word-fall-through
// read, fill count, programmable almost-full/almost-empty and sticky error flags.
module fifo_param #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    parameter  int AF_THRESH  = DEPTH - 2,
    parameter  int AE_THRESH  = 2,
    parameter  bit FWFT       = 1'b0,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH:0] AF_LIMIT = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LIMIT = (ADDR_WIDTH + 1)'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
        $error("fifo_param: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_en, rd_en;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

    // Status depends only on the registered pointers, never on wr/rd.
    always_comb begin
        count        = wr_ptr_q - rd_ptr_q;
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_idx == rd_idx);
        almost_full  = (count >= AF_LIMIT);
        almost_empty = (count <= AE_LIMIT);
    end

    // NOTE: every signal driven in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        wr_en       = wr & ~full;
        rd_en       = rd & ~empty;
        wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
        rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
        data_out_d  = rd_en ? mem[rd_idx] : data_out_q;
        overflow_d  = (overflow_q & ~clr_err) | (wr & full);
        underflow_d = (underflow_q & ~clr_err) | (rd & empty);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which words are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= data_in;
        end
    end

    assign data_out  = FWFT ? mem[rd_idx] : data_out_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed stimulus on a standard-mode and an FWFT
// instance, with a scoreboard queue of expected read words checked by a separate monitor.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst, wr, rd, clr_err;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_rst, f_wr, f_rd, f_clr_err;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rst(f_rst), .wr(f_wr), .data_in(f_data_in), .rd(f_rd), .data_out(f_data_out),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge; inputs are then changed 1 ns after it, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Standard-mode read data is valid in the cycle after an accepted read edge.
    always @(posedge clk) begin
        if (!rst && rd && !empty) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL read_data: got 0x%0h, expected no read", data_out);
            end else begin
                check("read_data", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         wr_cnt;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
        f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_clr_err = 1'b0; f_data_in = '0;
        tick();
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_almost_empty", int'(almost_empty), 1);
        check("rst_almost_full", int'(almost_full), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_underflow", int'(underflow), 0);
        rst = 1'b0; f_rst = 1'b0;

        // Fill with 0x00..0x0F, then one write too many.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 8'(i);
            tick();
            check("fill_count", int'(count), i + 1);
            check("fill_almost_full", int'(almost_full), (i + 1 >= 14) ? 1 : 0);
        end
        check("fill_full", int'(full), 1);
        data_in = 8'hAA;
        tick();
        wr = 1'b0;
        check("ovf_flag", int'(overflow), 1);
        check("ovf_count", int'(count), 16);

        // Drain in order, then one read too many.
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1; exp_q.push_back(8'(i));
            tick();
            check("drain_almost_empty", int'(almost_empty), (15 - i <= 2) ? 1 : 0);
        end
        check("drain_empty", int'(empty), 1);
        tick();
        rd = 1'b0;
        check("udf_flag", int'(underflow), 1);
        check("udf_data_hold", int'(data_out), 8'h0F);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_overflow", int'(overflow), 0);
        check("clr_underflow", int'(underflow), 0);

        // Simultaneous read and write at count 5.
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; data_in = 8'(8'h10 + i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1; rd = 1'b1; data_in = 8'(8'h20 + i);
            exp_q.push_back(i < 5 ? 8'(8'h10 + i) : 8'(8'h20 + i - 5));
            tick();
            check("simul_count", int'(count), 5);
        end
        wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd = 1'b1; exp_q.push_back(8'(8'h25 + i));
            tick();
        end
        rd = 1'b0;
        check("simul_drained", int'(empty), 1);

        // Simultaneous access while full: only the read is accepted.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 8'(8'h30 + i);
            tick();
        end
        wr = 1'b1; rd = 1'b1; data_in = 8'hBB; exp_q.push_back(8'h30);
        tick();
        wr = 1'b0;
        check("full_simul_count", int'(count), 15);
        check("full_simul_overflow", int'(overflow), 1);
        for (int i = 1; i < 16; i++) begin
            rd = 1'b1; exp_q.push_back(8'(8'h30 + i));
            tick();
        end
        rd = 1'b0;

        // Simultaneous access while empty: only the write is accepted.
        wr = 1'b1; rd = 1'b1; data_in = 8'hCC;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("empty_simul_count", int'(count), 1);
        check("empty_simul_underflow", int'(underflow), 1);
        rd = 1'b1; clr_err = 1'b1; exp_q.push_back(8'hCC);
        tick();
        rd = 1'b0; clr_err = 1'b0;

        // Wrap-around: two writes per read until well filled, then balanced, then drain.
        wr_cnt = 0;
        for (int i = 0; wr_cnt < 40; i++) begin
            rd = (model_q.size() > 0) && ((i % 2 == 1) || (model_q.size() >= 12));
            if (rd) exp_q.push_back(model_q.pop_front());
            d = 8'($urandom_range(0, 255));
            wr = 1'b1; data_in = d; model_q.push_back(d); wr_cnt++;
            tick();
            check("wrap_count", int'(count), model_q.size());
        end
        wr = 1'b0;
        while (model_q.size() > 0) begin
            rd = 1'b1; exp_q.push_back(model_q.pop_front());
            tick();
        end
        rd = 1'b0;
        check("wrap_empty", int'(empty), 1);

        // Mid-stream reset discards contents and error flags.
        rd = 1'b1;
        tick();
        rd = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1; data_in = 8'(8'h60 + i);
            tick();
        end
        wr = 1'b0;
        check("pre_rst_count", int'(count), 9);
        check("pre_rst_underflow", int'(underflow), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_overflow", int'(overflow), 0);
        check("mid_rst_underflow", int'(underflow), 0);
        wr = 1'b1; data_in = 8'h77;
        tick();
        wr = 1'b0; rd = 1'b1; exp_q.push_back(8'h77);
        tick();
        rd = 1'b0;

        // A set condition in the same cycle as clr_err wins.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 8'(i);
            tick();
        end
        clr_err = 1'b1;
        tick();
        wr = 1'b0;
        check("set_beats_clear", int'(overflow), 1);
        tick();
        clr_err = 1'b0;
        check("clear_alone", int'(overflow), 0);

        // FWFT instance: written word appears without a read.
        check("fwft_rst_empty", int'(f_empty), 1);
        f_wr = 1'b1; f_data_in = 8'h5A;
        tick();
        f_data_in = 8'h6B;
        check("fwft_empty_after_wr", int'(f_empty), 0);
        check("fwft_show_first", int'(f_data_out), 8'h5A);
        tick();
        f_wr = 1'b0;
        check("fwft_hold_first", int'(f_data_out), 8'h5A);
        check("fwft_count", int'(f_count), 2);
        f_rd = 1'b1;
        tick();
        check("fwft_show_next", int'(f_data_out), 8'h6B);
        check("fwft_not_empty", int'(f_empty), 0);
        tick();
        f_rd = 1'b0;
        check("fwft_empty_final", int'(f_empty), 1);

        tick();
        tick();
        check("pending_reads", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO that succeeds the fixed-configuration `fifo` block. It keeps the same core write/read/full/empty interface and adds:
- configurable width and depth,
- a first-word-fall-through (FWFT) read mode,
- a fill count with programmable almost-full and almost-empty flags,
- sticky overflow and underflow error flags.

It is the standard buffering element between producer and consumer stages in the single-clock domain.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 16, number of entries; power of two, ≥ 2
- ADDR_WIDTH, $clog2(DEPTH), derived locally; not overridden by the instantiator
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- wr  in  1  write request
- data_in  in  DATA_WIDTH  write data, sampled with wr
- rd  in  1  read request
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH × DATA_WIDTH register array. The array is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide; the MSB is the wrap bit.
  - The low ADDR_WIDTH bits index the array.
  - Pointers wrap naturally modulo 2·DEPTH.
- count = wr_ptr − rd_ptr, computed modulo 2^(ADDR_WIDTH+1).
- Accepted write: wr_en = wr & ~full.
  - On the edge, the array stores data_in at wr_ptr, then wr_ptr increments.
- Accepted read: rd_en = rd & ~empty; rd_ptr then increments.
- Simultaneous wr and rd:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: only the read is accepted; the write is dropped and sets overflow.
  - Empty: only the write is accepted; the read is ignored and sets underflow.
- Standard mode (FWFT=0): data_out is a register.
  - On a rd_en edge it loads the array entry at rd_ptr.
  - Otherwise it holds its value.
- FWFT mode (FWFT=1): data_out = array[rd_ptr] combinationally.
  - It is valid whenever empty = 0; rd consumes the shown word.
  - When empty = 1, data_out is don't-care.
- Status outputs (full, empty, almost_full, almost_empty, count) are combinational functions of the registered pointers only. They never depend combinationally on wr or rd.
- Error flags:
  - overflow sets on any edge with wr & full; underflow sets on any edge with rd & empty.
  - clr_err clears both flags.
  - If a set condition and clr_err occur in the same cycle, the set wins.
- Misconfiguration: AF_THRESH > DEPTH or AE_THRESH ≥ DEPTH triggers an elaboration-time $error.

## Timing
- Reset values, one edge after rst = 1:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = (AF_THRESH == 0)
  - data_out = 0 in standard mode
  - overflow = underflow = 0
- Reset has priority over every other input. Reset mid-operation discards all contents on that edge; the next cycle behaves as freshly reset.
- Write-to-status latency: flags and count reflect an accepted write or read in the cycle after the accepting edge.
- Standard-mode read latency: data_out is valid in the cycle after the rd_en edge. It is not valid in the same cycle in which rd is asserted.
- FWFT write-to-read latency: after a write into an empty FIFO, empty deasserts and data_out shows the word one cycle after the write edge.
- A full FIFO accepts a new write in the cycle after a read edge. An empty FIFO accepts a new read in the cycle after a write edge.
- Wrap bit: full = (MSBs differ, low bits equal); empty = (pointers equal).

## Test plan
- Reset and fill (DATA_WIDTH=8, DEPTH=16, FWFT=0):
  - During rst: all outputs at their reset values.
  - After 16 writes of 0x00..0x0F: count=16, full=1, almost_full=1 from count 14.
  - A 17th write (0xAA) sets overflow=1; count stays 16 and 0xAA is never read back.
- Drain order: 16 reads return 0x00..0x0F in order, each on data_out in the cycle after its read edge.
  - Then empty=1 and almost_empty=1 from count 2.
  - A 17th read sets underflow=1; data_out holds 0x0F.
- Simultaneous access:
  - At count=5, 10 cycles of wr=rd=1: count stays 5 and reads return the prior 5 words, then the new ones, in order.
  - At full, wr=rd=1: count goes to 15 and overflow=1.
  - At empty, wr=rd=1: count goes to 1 and underflow=1.
- Wrap-around: 40 writes and 40 reads interleaved as 2:1, then drained, with random data. Every word matches a scoreboard queue in order, and pointers pass the wrap bit at least twice.
- FWFT mode (FWFT=1):
  - Write 0x5A into an empty FIFO: next cycle empty=0 and data_out=0x5A with no rd.
  - rd pops 0x5A and the FIFO shows the next word or empty=1.
- Reset mid-stream and error clear:
  - Assert rst with count=9: next cycle count=0, empty=1, overflow=underflow=0.
  - clr_err asserted in the same cycle as wr & full leaves overflow=1.
